// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Opcode/funct constants, mux-select encodings and the control bundle.
package control_pkg;

  typedef enum logic [3:0] {
    RESET     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    LW_WB     = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    BEQ       = 4'd11,
    JUMP      = 4'd12,
    HALT      = 4'd13,
    EXCEPT    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_BREAK = 6'h0d;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       exception;
  } ctl_t;

  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

  function automatic logic rfunct_ok(logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) ||
           (f == FN_AND) || (f == FN_XOR);
  endfunction

endpackage

// File: rtl/control_unit_fsm_if.sv
// Control bus between the main FSM and the datapath.
// master = control unit, slave = datapath / ALU control.
interface control_unit_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Opcode;
  logic [5:0]         Funct;
  logic               Break;
  logic               PCWrite;
  logic               PCWriteCond;
  logic [1:0]         PCSource;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               Halted;
  logic               Exception;
  logic [STATE_W-1:0] State;

  modport master (
    input  Opcode, Funct, Break,
    output PCWrite, PCWriteCond, PCSource,
    output IorD, MemRead, MemWrite, IRWrite,
    output ALUSrcA, ALUSrcB, ALUOp,
    output RegWrite, RegDst, MemtoReg,
    output Halted, Exception, State
  );

  modport slave (
    output Opcode, Funct, Break,
    input  PCWrite, PCWriteCond, PCSource,
    input  IorD, MemRead, MemWrite, IRWrite,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  RegWrite, RegDst, MemtoReg,
    input  Halted, Exception, State
  );
endinterface

// File: rtl/control_unit_fsm_mem_wait_counter.sv
// Memory wait-state counter: load on state entry, count down to zero.
// zero marks the final cycle of a memory access state.
module mem_wait_counter #(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW =
    (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  logic [CW-1:0] cnt;

  // load has priority; hold at zero once reached
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_WAIT);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle MIPS main control FSM with Moore-decoded control outputs.
// Sequences fetch/decode/execute/memory/writeback; halts on break/illegal.
module control_unit_fsm
  import control_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 4
) (
  input  logic clk,
  input  logic reset,
  control_unit_fsm_if.master bus
);
  state_t state;
  state_t nxt;
  logic   zero;
  logic   load;
  logic   dec;
  ctl_t   c;

  logic is_r;
  logic is_ldst;
  logic is_addi;
  logic is_beq;
  logic is_j;

  assign is_r    = bus.Opcode == OP_RTYPE;
  assign is_ldst = bus.Opcode == OP_LW ||
                   bus.Opcode == OP_SW;
  assign is_addi = bus.Opcode == OP_ADDI;
  assign is_beq  = bus.Opcode == OP_BEQ;
  assign is_j    = bus.Opcode == OP_J;

  // counter reloads whenever a timed state is freshly entered
  assign load = is_mem_state(nxt) && (nxt != state);
  assign dec  = is_mem_state(state);

  mem_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .dec  (dec),
    .zero (zero)
  );

  // next-state selection
  always_comb begin
    nxt = state;
    unique case (state)
      RESET:     nxt = FETCH;
      FETCH:     if (zero) nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_r && bus.Break:
            nxt = HALT;
          is_r && !bus.Break && rfunct_ok(bus.Funct):
            nxt = R_EXEC;
          is_ldst: nxt = MEM_ADDR;
          is_addi: nxt = ADDI_EXEC;
          is_beq:  nxt = BEQ;
          is_j:    nxt = JUMP;
          default: nxt = EXCEPT;
        endcase
      end
      MEM_ADDR: begin
        if (bus.Opcode == OP_LW)      nxt = MEM_READ;
        else if (bus.Opcode == OP_SW) nxt = MEM_WRITE;
        else                          nxt = EXCEPT;
      end
      MEM_READ:  if (zero) nxt = LW_WB;
      MEM_WRITE: if (zero) nxt = FETCH;
      LW_WB:     nxt = FETCH;
      R_EXEC:    nxt = R_WB;
      R_WB:      nxt = FETCH;
      ADDI_EXEC: nxt = ADDI_WB;
      ADDI_WB:   nxt = FETCH;
      BEQ:       nxt = FETCH;
      JUMP:      nxt = FETCH;
      HALT:      nxt = HALT;
      EXCEPT:    nxt = EXCEPT;
      default:   nxt = EXCEPT;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RESET;
    else        state <= nxt;
  end

  // Moore output decode from state and wait counter
  always_comb begin
    c = '0;
    unique case (state)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        if (zero) begin
          c.ir_write  = 1'b1;
          c.pc_write  = 1'b1;
          c.pc_source = PCSRC_ALU;
        end
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      LW_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ADDI_WB:  c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      HALT:    c.halted    = 1'b1;
      EXCEPT:  c.exception = 1'b1;
      default: c = '0;
    endcase
  end

  assign bus.PCWrite     = c.pc_write;
  assign bus.PCWriteCond = c.pc_write_cond;
  assign bus.PCSource    = c.pc_source;
  assign bus.IorD        = c.iord;
  assign bus.MemRead     = c.mem_read;
  assign bus.MemWrite    = c.mem_write;
  assign bus.IRWrite     = c.ir_write;
  assign bus.ALUSrcA     = c.alu_src_a;
  assign bus.ALUSrcB     = c.alu_src_b;
  assign bus.ALUOp       = c.alu_op;
  assign bus.RegWrite    = c.reg_write;
  assign bus.RegDst      = c.reg_dst;
  assign bus.MemtoReg    = c.mem_to_reg;
  assign bus.Halted      = c.halted;
  assign bus.Exception   = c.exception;
  assign bus.State       = STATE_W'(state);
endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: three instances (MEM_WAIT 0/2/3) driven
// with directed and random instructions against a per-instruction model.
module tb_control_unit_fsm;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       h;
    logic       e;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst [3];
  logic [5:0] op  [3];
  logic [5:0] fn  [3];
  logic       brk [3];
  ctl_t       obs [3];
  logic [3:0] st  [3];

  int   tests = 0;
  int   fails = 0;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    control_unit_fsm_if #(.STATE_W(4)) bus();

    control_unit_fsm #(
      .MEM_WAIT(g == 0 ? 0 : (g == 1 ? 2 : 3)),
      .STATE_W (4)
    ) dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (bus.master)
    );

    assign bus.Opcode = op[g];
    assign bus.Funct  = fn[g];
    assign bus.Break  = brk[g];
    assign obs[g] = {
      bus.PCWrite, bus.PCWriteCond, bus.PCSource,
      bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
      bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
      bus.RegWrite, bus.RegDst, bus.MemtoReg,
      bus.Halted, bus.Exception
    };
    assign st[g] = bus.State;
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h",
               tag, got, exp);
    end
  endtask

  // hold reset low 3 cycles, all outputs must be zero
  task automatic do_reset(int d);
    rst[d] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk($sformatf("d%0d_rst_ctl", d), 32'(obs[d]), 0);
      chk($sformatf("d%0d_rst_state", d), 32'(st[d]), 0);
    end
    rst[d] = 1'b1;
  endtask

  // expected per-cycle control vectors for one instruction
  task automatic build(int w, logic [5:0] o, logic [5:0] f,
                       output bit stuck);
    ctl_t c;
    bit   rlegal;
    exp_q.delete();
    stuck = 1'b0;
    rlegal = (f == 6'h20) || (f == 6'h22) ||
             (f == 6'h24) || (f == 6'h26);
    for (int i = 0; i <= w; i++) begin
      c = '0; c.mr = 1; c.asb = 2'b01;
      if (i == w) begin c.irw = 1; c.pcw = 1; end
      exp_q.push_back(c);
    end
    c = '0; c.asb = 2'b11;
    exp_q.push_back(c);
    if (o == 6'h00 && f == 6'h0d) begin
      repeat (12) begin c = '0; c.h = 1; exp_q.push_back(c); end
      stuck = 1'b1;
    end else if (o == 6'h00 && rlegal) begin
      c = '0; c.asa = 1; c.aop = 2'b10; exp_q.push_back(c);
      c = '0; c.rw = 1; c.rd = 1; exp_q.push_back(c);
    end else if (o == 6'h23 || o == 6'h2b) begin
      c = '0; c.asa = 1; c.asb = 2'b10; exp_q.push_back(c);
      repeat (w + 1) begin
        c = '0; c.iord = 1;
        if (o == 6'h23) c.mr = 1; else c.mw = 1;
        exp_q.push_back(c);
      end
      if (o == 6'h23) begin
        c = '0; c.rw = 1; c.m2r = 1; exp_q.push_back(c);
      end
    end else if (o == 6'h08) begin
      c = '0; c.asa = 1; c.asb = 2'b10; exp_q.push_back(c);
      c = '0; c.rw = 1; exp_q.push_back(c);
    end else if (o == 6'h04) begin
      c = '0; c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01;
      exp_q.push_back(c);
    end else if (o == 6'h02) begin
      c = '0; c.pcw = 1; c.pcs = 2'b10; exp_q.push_back(c);
    end else begin
      repeat (12) begin c = '0; c.e = 1; exp_q.push_back(c); end
      stuck = 1'b1;
    end
  endtask

  task automatic run_instr(int d, int w, logic [5:0] o,
                           logic [5:0] f);
    bit stuck;
    op[d]  = o;
    fn[d]  = f;
    brk[d] = (f == 6'h0d);
    build(w, o, f, stuck);
    foreach (exp_q[i]) begin
      @(negedge clk);
      chk($sformatf("d%0d_op%02h_fn%02h_c%0d", d, o, f, i),
          32'(obs[d]), 32'(exp_q[i]));
    end
    if (stuck) do_reset(d);
  endtask

  // sw on the MEM_WAIT=3 instance, reset lands in MEM_WRITE cycle 1
  task automatic reset_mid_write();
    bit stuck;
    op[2] = 6'h2b; fn[2] = 6'h00; brk[2] = 1'b0;
    build(3, 6'h2b, 6'h00, stuck);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("mw_pre_c%0d", i), 32'(obs[2]),
          32'(exp_q[i]));
    end
    rst[2] = 1'b0;
    #1;
    chk("mw_async_memwrite", 32'(obs[2].mw), 0);
    chk("mw_async_ctl", 32'(obs[2]), 0);
    do_reset(2);
    run_instr(2, 3, 6'h00, 6'h20);
  endtask

  logic [5:0] dop [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b,
                           6'h04, 6'h02, 6'h08, 6'h00, 6'h3f, 6'h00};
  logic [5:0] dfn [12] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h11, 6'h05,
                           6'h00, 6'h3a, 6'h20, 6'h0d, 6'h20, 6'h27};
  logic [5:0] lops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
  logic [5:0] rfns [6] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h0d, 6'h27};

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; op[i] = '0; fn[i] = '0; brk[i] = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      int w;
      w = (d == 0) ? 0 : ((d == 1) ? 2 : 3);
      do_reset(d);
      for (int i = 0; i < 12; i++) run_instr(d, w, dop[i], dfn[i]);
      for (int i = 0; i < 14; i++) begin
        logic [5:0] o;
        logic [5:0] f;
        int k;
        k = $urandom_range(0, 3);
        f = 6'($urandom_range(0, 63));
        if (k == 0) begin
          o = 6'h00; f = rfns[$urandom_range(0, 5)];
        end else if (k == 3) begin
          o = 6'($urandom_range(0, 63));
        end else begin
          o = lops[$urandom_range(0, 5)];
        end
        run_instr(d, w, o, f);
      end
      rst[d] = 1'b0;
    end
    rst[2] = 1'b1;
    reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
